// File: rtl/divider_16by8bits.sv
// Sequential restoring divider: WIDTH_N-bit dividend / WIDTH_D-bit divisor, one quotient bit per
// clock, MSB first, st/done handshake. Define DIVIDER_SIGNED_EN for two's-complement operands.
//
// state  | meaning
// S_IDLE | waiting for an accepted st
// S_CALC | one restoring iteration per clock, WIDTH_N clocks, busy=1
// S_DONE | quot/rem/div0 just loaded, done=1 for this one cycle; st here starts the next op

module divider_16by8bits #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st,
    input  logic [WIDTH_N-1:0] dvd,
    input  logic [WIDTH_D-1:0] dvs,
    output logic [WIDTH_N-1:0] quot,
    output logic [WIDTH_D-1:0] rem,
    output logic               busy,
    output logic               done,
    output logic               div0
);

    localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH_D-1:0] r_p;
    logic [WIDTH_N-1:0] r_q;
    logic [WIDTH_D-1:0] r_dvs;
    logic [WIDTH_N-1:0] r_quot;
    logic [WIDTH_D-1:0] r_rem;
    logic               r_div0;

    logic               w_accept;
    logic               w_dvs_zero;
    logic               w_last;
    logic [WIDTH_N-1:0] w_dvd_mag;
    logic [WIDTH_D-1:0] w_dvs_mag;
    logic [WIDTH_D:0]   w_p_shift;
    logic               w_ge;
    logic [WIDTH_D-1:0] w_p_nxt;
    logic [WIDTH_N-1:0] w_q_nxt;
    logic [WIDTH_N-1:0] w_quot_fix;
    logic [WIDTH_D-1:0] w_rem_fix;

    assign w_accept   = st && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_dvs_zero = (dvs == '0);
    assign w_last     = (r_cnt == CNT_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (st) begin
                    w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (st) begin
                    w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC);
        done = (r_state == S_DONE);
    end

    // ---------------------------------------------------------------- operand conditioning
`ifdef DIVIDER_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = dvd[WIDTH_N-1];
    assign w_dvs_neg = dvs[WIDTH_D-1];
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    assign w_dvd_mag = w_dvd_neg ? -dvd : dvd;
    assign w_dvs_mag = w_dvs_neg ? -dvs : dvs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept && !w_dvs_zero) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end

    assign w_quot_fix = r_neg_q ? -w_q_nxt : w_q_nxt;
    assign w_rem_fix  = r_neg_r ? -w_p_nxt : w_p_nxt;
`else
    assign w_dvd_mag  = dvd;
    assign w_dvs_mag  = dvs;
    assign w_quot_fix = w_q_nxt;
    assign w_rem_fix  = w_p_nxt;
`endif

    // ---------------------------------------------------------------- restoring iteration
    // The stored partial remainder is always < divisor, so only the shifted value needs the extra bit.
    always_comb begin
        w_p_shift = {r_p, r_q[WIDTH_N-1]};
        w_ge      = (w_p_shift >= {1'b0, r_dvs});
        if (w_ge) begin
            w_p_nxt = WIDTH_D'(w_p_shift - {1'b0, r_dvs});
        end else begin
            w_p_nxt = w_p_shift[WIDTH_D-1:0];
        end
        w_q_nxt = {r_q[WIDTH_N-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_p    <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_div0 <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (w_dvs_zero) begin
                r_quot <= '1;
                r_rem  <= dvd[WIDTH_D-1:0];
                r_div0 <= 1'b1;
            end else begin
                r_p    <= '0;
                r_q    <= w_dvd_mag;
                r_dvs  <= w_dvs_mag;
                r_div0 <= 1'b0;
            end
        end else if (r_state == S_CALC) begin
            r_p   <= w_p_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            // Results are published only on the last iteration, together with the move to DONE.
            if (w_last) begin
                r_quot <= w_quot_fix;
                r_rem  <= w_rem_fix;
            end
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem;
    assign div0 = r_div0;

endmodule

// File: tb/tb_divider_16by8bits.sv
// Self-checking bench for divider_16by8bits; honours DIVIDER_SIGNED_EN in its reference model.
module tb_divider_16by8bits;

    logic        clk;
    logic        rst_n;
    logic        st;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic        busy;
    logic        done;
    logic        div0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } vec_t;

    divider_16by8bits #(.WIDTH_N(16), .WIDTH_D(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .st   (st),
        .dvd  (dvd),
        .dvs  (dvs),
        .quot (quot),
        .rem  (rem),
        .busy (busy),
        .done (done),
        .div0 (div0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    // Reference: plain arithmetic on the operand values.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r, output logic z);
        int sa, sb;
        sa = 0;
        sb = 0;
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = a[7:0];
            z = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 8'(sa % sb);
`else
            sa = int'(a);
            sb = int'(b);
            q  = 16'(sa / sb);
            r  = 8'(sa % sb);
`endif
            z = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is first seen (or after the budget).
    // lat = number of rising edges after the accepting edge before done is seen.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output int nbusy, output logic both);
        dvd = a;
        dvs = b;
        st  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st    = 1'b0;
        dvd   = 16'($urandom);
        dvs   = 8'($urandom);
        lat   = -1;
        nbusy = 0;
        both  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) nbusy++;
            if (busy && done) both = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        st    = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({quot, rem, busy, done, div0} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: quot=%h rem=%h busy=%b done=%b div0=%b, required all 0",
                     quot, rem, busy, done, div0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        vec_t v[$];
        int   lat, nb, exp_lat;
        logic both;
        v.push_back({16'd1000,  8'd7,   16'd142,   8'd6,   1'b0});
        v.push_back({16'hFFFF,  8'h01,  16'hFFFF,  8'h00,  1'b0});
        v.push_back({16'h1234,  8'h00,  16'hFFFF,  8'h34,  1'b1});
`ifdef DIVIDER_SIGNED_EN
        v.push_back({16'h0005,  8'hFF,  16'hFFFB,  8'h00,  1'b0});
        v.push_back({16'hFF9C,  8'h07,  16'hFFF2,  8'hFE,  1'b0});
        v.push_back({16'h0064,  8'hF9,  16'hFFF2,  8'h02,  1'b0});
        v.push_back({16'h8000,  8'hFF,  16'h8000,  8'h00,  1'b0});
`else
        v.push_back({16'h0005,  8'hFF,  16'h0000,  8'h05,  1'b0});
        v.push_back({16'h8000,  8'h80,  16'h0100,  8'h00,  1'b0});
        v.push_back({16'hFFFF,  8'hFF,  16'h0101,  8'h00,  1'b0});
`endif
        foreach (v[i]) begin
            exp_lat = (v[i].b == 8'd0) ? 0 : 16;
            run_op(v[i].a, v[i].b, lat, nb, both);
            n_checks += 6;
            if (quot !== v[i].q) begin
                n_fail++;
                $display("FAIL dir_quot[%0d]: got %h, required %h", i, quot, v[i].q);
            end
            if (rem !== v[i].r) begin
                n_fail++;
                $display("FAIL dir_rem[%0d]: got %h, required %h", i, rem, v[i].r);
            end
            if (div0 !== v[i].z) begin
                n_fail++;
                $display("FAIL dir_div0[%0d]: got %b, required %b", i, div0, v[i].z);
            end
            if (lat != exp_lat) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d, required %0d", i, lat, exp_lat);
            end
            if (nb != exp_lat) begin
                n_fail++;
                $display("FAIL dir_busy_cycles[%0d]: got %0d, required %0d", i, nb, exp_lat);
            end
            if (both !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_busy_and_done[%0d]: got %b, required 0", i, both);
            end
            @(negedge clk);
            n_checks += 2;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_done_pulse[%0d]: done=%b one cycle later, required 0", i, done);
            end
            if (quot !== v[i].q || rem !== v[i].r || div0 !== v[i].z) begin
                n_fail++;
                $display("FAIL dir_hold[%0d]: got %h/%h/%b, required %h/%h/%b",
                         i, quot, rem, div0, v[i].q, v[i].r, v[i].z);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        ez, both;
        int          lat, nb, sel;
        for (int i = 0; i < 40; i++) begin
            a   = 16'($urandom);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       b = 8'h00;
                1:       b = 8'hFF;
                2:       b = 8'h01;
                3:       b = 8'h80;
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0) a = 16'h8000;
            model(a, b, eq, er, ez);
            run_op(a, b, lat, nb, both);
            n_checks += 4;
            if (quot !== eq || rem !== er) begin
                n_fail++;
                $display("FAIL rnd_result[%0d] %h/%h: got q=%h r=%h, required q=%h r=%h",
                         i, a, b, quot, rem, eq, er);
            end
            if (div0 !== ez) begin
                n_fail++;
                $display("FAIL rnd_div0[%0d]: got %b, required %b", i, div0, ez);
            end
            if (lat != ((b == 8'd0) ? 0 : 16)) begin
                n_fail++;
                $display("FAIL rnd_latency[%0d]: got %0d, required %0d", i, lat, (b == 8'd0) ? 0 : 16);
            end
            if (both !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_busy_and_done[%0d]: got %b, required 0", i, both);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_st_in_calc;
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        ez;
        int          lat;
        a = 16'h9ABC;
        b = 8'h0D;
        model(a, b, eq, er, ez);
        dvd = a;
        dvs = b;
        st  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st  = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            st = (k == 6) || (k == 9);
            if (k == 6) begin
                dvd = 16'h0001;
                dvs = 8'h03;
            end
            if (k == 9) dvs = 8'h00;
            @(negedge clk);
        end
        st = 1'b0;
        n_checks += 3;
        if (lat != 16) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d, required 16", lat);
        end
        if (quot !== eq || rem !== er) begin
            n_fail++;
            $display("FAIL ignore_result: got q=%h r=%h, required q=%h r=%h", quot, rem, eq, er);
        end
        if (div0 !== ez) begin
            n_fail++;
            $display("FAIL ignore_div0: got %b, required %b", div0, ez);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] as [4];
        logic [7:0]  bs [4];
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez, both;
        int          lat, nb;
        as = '{16'hBEEF, 16'h0F0F, 16'h4321, 16'h00FF};
        bs = '{8'h11,    8'h07,    8'h00,    8'h10};
        for (int i = 0; i < 4; i++) begin
            model(as[i], bs[i], eq, er, ez);
            run_op(as[i], bs[i], lat, nb, both);
            n_checks += 3;
            if (lat != ((bs[i] == 8'd0) ? 0 : 16)) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d, required %0d", i, lat, (bs[i] == 8'd0) ? 0 : 16);
            end
            if (quot !== eq || rem !== er) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got q=%h r=%h, required q=%h r=%h", i, quot, rem, eq, er);
            end
            if (div0 !== ez) begin
                n_fail++;
                $display("FAIL b2b_div0[%0d]: got %b, required %b", i, div0, ez);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez, both;
        int          lat, nb, seen;
        dvd = 16'hCAFE;
        dvs = 8'h05;
        st  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b at iteration 8, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({quot, rem, busy, done, div0} !== 27'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: quot=%h rem=%h busy=%b done=%b div0=%b, required all 0",
                     quot, rem, busy, done, div0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_no_done: %0d cycles with busy/done after abort, required 0", seen);
        end
        model(16'h7531, 8'h2B, eq, er, ez);
        run_op(16'h7531, 8'h2B, lat, nb, both);
        n_checks += 2;
        if (lat != 16 || nb != 16) begin
            n_fail++;
            $display("FAIL mid_rerun_timing: latency=%0d busy=%0d, required 16 16", lat, nb);
        end
        if (quot !== eq || rem !== er || div0 !== ez) begin
            n_fail++;
            $display("FAIL mid_rerun_result: got %h/%h/%b, required %h/%h/%b", quot, rem, div0, eq, er, ez);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_st_in_calc();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
